// File: rtl/display_share_arbiter.sv
// Round-robin owner selection for the shared 4-digit display, with a minimum
// dwell per owner and live tracking of the owner's fields while it holds.
module display_share_arbiter #(
  parameter int DW          = 6,
  parameter int HOLD_CYCLES = 100000000,
  parameter int CW          = 27
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    req,
  input  logic [DW-1:0] s0_data0,
  input  logic [DW-1:0] s0_data1,
  input  logic [DW-1:0] s1_data0,
  input  logic [DW-1:0] s1_data1,
  input  logic [DW-1:0] s2_data0,
  input  logic [DW-1:0] s2_data1,
  output logic [DW-1:0] data0,
  output logic [DW-1:0] data1,
  output logic [2:0]    grant,
  output logic          busy
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ptr;   // last winner; equals the owner while in HOLD

  logic [3:0][DW-1:0] w_f0, w_f1;
  logic [1:0]         w_win;
  logic               w_win_vld;
  logic               w_evt;
  logic [2:0]         w_idx;

  assign w_f0 = {DW'(0), s2_data0, s1_data0, s0_data0};
  assign w_f1 = {DW'(0), s2_data1, s1_data1, s0_data1};

  // Scan ptr+1, ptr+2, ptr+3 (mod 3); walking backwards lets the nearest hit win.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 2'd0;
    w_idx     = 3'd0;
    for (int k = 3; k >= 1; k--) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= 3'd3) w_idx = w_idx - 3'd3;
      if (req[w_idx[1:0]]) begin
        w_win_vld = 1'b1;
        w_win     = w_idx[1:0];
      end
    end
  end

  assign w_evt = (r_cnt == '0) || !req[r_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 2'd2;
      grant   <= 3'b000;
      busy    <= 1'b0;
      data0   <= '0;
      data1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_state <= S_HOLD;
            r_cnt   <= RELOAD;
            r_ptr   <= w_win;
            grant   <= 3'b001 << w_win;
            busy    <= 1'b1;
            data0   <= w_f0[w_win];
            data1   <= w_f1[w_win];
          end
        end
        S_HOLD: begin
          if (!w_evt) begin
            r_cnt <= r_cnt - CW'(1);
            data0 <= w_f0[r_ptr];
            data1 <= w_f1[r_ptr];
          end else if (!w_win_vld) begin
            // data stays frozen on the last shown values
            r_state <= S_IDLE;
            grant   <= 3'b000;
            busy    <= 1'b0;
          end else begin
            r_cnt <= RELOAD;
            r_ptr <= w_win;
            grant <= 3'b001 << w_win;
            data0 <= w_f0[w_win];
            data1 <= w_f1[w_win];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
